// File: rtl/seq_stage_controller_if.sv
// seq_stage_controller_if: handshake/status bundle of the SEQ sequencer.
// slave: controller side; master: environment (fetch, data memory, host).
interface seq_stage_controller_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 start;
  logic [3:0]           icode;
  logic                 imem_error;
  logic                 func_error;
  logic                 mem_ready;
  logic                 dmem_error;
`ifdef SEQ_SINGLE_STEP_EN
  logic                 step;
`endif
  logic                 fetch_en;
  logic                 decode_en;
  logic                 execute_en;
  logic                 memory_en;
  logic                 writeback_en;
  logic                 pc_update_en;
  logic [2:0]           stat;
  logic                 halted;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [CNT_WIDTH-1:0] instr_count;

`ifdef SEQ_SINGLE_STEP_EN
  modport slave (
    input  start, icode, imem_error, func_error,
    input  mem_ready, dmem_error, step,
    output fetch_en, decode_en, execute_en, memory_en,
    output writeback_en, pc_update_en,
    output stat, halted, cycle_count, instr_count
  );
  modport master (
    output start, icode, imem_error, func_error,
    output mem_ready, dmem_error, step,
    input  fetch_en, decode_en, execute_en, memory_en,
    input  writeback_en, pc_update_en,
    input  stat, halted, cycle_count, instr_count
  );
`else
  modport slave (
    input  start, icode, imem_error, func_error,
    input  mem_ready, dmem_error,
    output fetch_en, decode_en, execute_en, memory_en,
    output writeback_en, pc_update_en,
    output stat, halted, cycle_count, instr_count
  );
  modport master (
    output start, icode, imem_error, func_error,
    output mem_ready, dmem_error,
    input  fetch_en, decode_en, execute_en, memory_en,
    input  writeback_en, pc_update_en,
    input  stat, halted, cycle_count, instr_count
  );
`endif
endinterface

// File: rtl/seq_stage_controller.sv
// seq_stage_controller: SEQ Y86-64 sequencer stepping fetch..PC-update,
// one registered one-hot stage enable per cycle, faults -> stat, halt.
// Ports: clk; rst (sync, active-high); bus (slave): start, icode,
// imem_error, func_error, mem_ready, dmem_error in; six stage enables,
// stat, halted, cycle_count, instr_count out.
// Option: define SEQ_SINGLE_STEP_EN for bus.step and a PAUSE state.
module seq_stage_controller #(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   rst,
  seq_stage_controller_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPDATE,
    S_HALTED
`ifdef SEQ_SINGLE_STEP_EN
    ,
    S_PAUSE
`endif
  } state_t;

  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_HLT = 3'd2;
  localparam logic [2:0] ST_ADR = 3'd3;
  localparam logic [2:0] ST_INS = 3'd4;

  // tmo_q counts MEMORY cycles already completed, so the
  // MEM_TIMEOUT-th cycle is the last one allowed to wait.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [2:0]           stat_q, stat_d;
  logic [3:0]           icode_q, icode_d;
  logic [7:0]           tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] ins_q, ins_d;
  logic [5:0]           en_q, en_d;
  logic                 halted_q, halted_d;
  logic                 mem_class;
  logic                 active;

  assign mem_class = icode_q inside {4'h4, 4'h5, 4'h8,
                                     4'h9, 4'hA, 4'hB};

`ifdef SEQ_SINGLE_STEP_EN
  assign active = !(state_q inside {S_IDLE, S_HALTED, S_PAUSE});
`else
  assign active = !(state_q inside {S_IDLE, S_HALTED});
`endif

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    tmo_d   = tmo_q;
    ins_d   = ins_q;
    cyc_d   = cyc_q;
    if (active && !(&cyc_q)) cyc_d = cyc_q + CNT_ONE;
    unique case (state_q)
      S_IDLE: begin
`ifdef SEQ_SINGLE_STEP_EN
        if (bus.start) state_d = S_PAUSE;
`else
        if (bus.start) state_d = S_FETCH;
`endif
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        icode_d = bus.icode;
        priority case (1'b1)
          bus.imem_error: begin
            stat_d  = ST_ADR;
            state_d = S_HALTED;
          end
          bus.func_error: begin
            stat_d  = ST_INS;
            state_d = S_HALTED;
          end
          (bus.icode == 4'h0): begin
            stat_d  = ST_HLT;
            state_d = S_HALTED;
          end
          default: state_d = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        tmo_d   = '0;
        state_d = S_MEMORY;
      end
      S_MEMORY: begin
        if (!mem_class) begin
          state_d = S_WRITEBACK;
        end else begin
          priority case (1'b1)
            bus.dmem_error: begin
              stat_d  = ST_ADR;
              state_d = S_HALTED;
            end
            bus.mem_ready: state_d = S_WRITEBACK;
            (tmo_q == TMO_LAST): begin
              stat_d  = ST_ADR;
              state_d = S_HALTED;
            end
            default: tmo_d = tmo_q + 8'd1;
          endcase
        end
      end
      S_WRITEBACK: state_d = S_PCUPDATE;
      S_PCUPDATE: begin
        if (!(&ins_q)) ins_d = ins_q + CNT_ONE;
`ifdef SEQ_SINGLE_STEP_EN
        state_d = S_PAUSE;
`else
        state_d = S_FETCH;
`endif
      end
      S_HALTED: state_d = S_HALTED;
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE: if (bus.step) state_d = S_FETCH;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Enables are registered from the next state so they line up
  // exactly with the stage the machine is in.
  always_comb begin
    en_d     = '0;
    halted_d = 1'b0;
    unique case (state_d)
      S_FETCH:     en_d[5]  = 1'b1;
      S_DECODE:    en_d[4]  = 1'b1;
      S_EXECUTE:   en_d[3]  = 1'b1;
      S_MEMORY:    en_d[2]  = 1'b1;
      S_WRITEBACK: en_d[1]  = 1'b1;
      S_PCUPDATE:  en_d[0]  = 1'b1;
      S_HALTED:    halted_d = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      stat_q   <= ST_AOK;
      icode_q  <= '0;
      tmo_q    <= '0;
      cyc_q    <= '0;
      ins_q    <= '0;
      en_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stat_q   <= stat_d;
      icode_q  <= icode_d;
      tmo_q    <= tmo_d;
      cyc_q    <= cyc_d;
      ins_q    <= ins_d;
      en_q     <= en_d;
      halted_q <= halted_d;
    end
  end

  assign bus.fetch_en     = en_q[5];
  assign bus.decode_en    = en_q[4];
  assign bus.execute_en   = en_q[3];
  assign bus.memory_en    = en_q[2];
  assign bus.writeback_en = en_q[1];
  assign bus.pc_update_en = en_q[0];
  assign bus.stat         = stat_q;
  assign bus.halted       = halted_q;
  assign bus.cycle_count  = cyc_q;
  assign bus.instr_count  = ins_q;

endmodule

// File: doc/seq_stage_controller.md
Name: seq_stage_controller

Overview:
Sequencer for the 64-bit SEQ Y86 processor. It steps one instruction at a time through the six stages: fetch, decode, execute, memory, writeback and PC update. It asserts one stage-enable per cycle and waits on the data-memory handshake. It converts fetch and memory faults into the architectural status code, and it stops the machine on halt or fault.

Parameters:
CNT_WIDTH, 32, width of cycle_count and instr_count
MEM_TIMEOUT, 15, maximum cycles spent waiting for mem_ready before an ADR fault is raised (range 1..255)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
start  input  1  begin execution from IDLE (level or pulse)
icode  input  4  instruction code from the fetch stage
imem_error  input  1  fetch stage: PC out of instruction-memory range
func_error  input  1  fetch stage: invalid icode
mem_ready  input  1  data memory has completed the access
dmem_error  input  1  data memory address fault
fetch_en  output  1  fetch stage enable
decode_en  output  1  decode stage enable
execute_en  output  1  execute stage enable
memory_en  output  1  memory stage enable / request
writeback_en  output  1  register writeback enable
pc_update_en  output  1  PC register load enable
stat  output  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS
halted  output  1  machine is stopped
cycle_count  output  CNT_WIDTH  active cycles executed
instr_count  output  CNT_WIDTH  instructions retired

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Reset has priority in every state, including mid-instruction and HALTED.
- Reset values: state=IDLE, all enables 0, stat=1 (AOK), halted=0, both counters 0, latched icode 0, timeout counter 0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALTED.
- Enables are registered Moore outputs and are one-hot with the stage state. IDLE and HALTED drive all enables 0.
- IDLE: when start=1, go to FETCH on the next cycle. Otherwise stay in IDLE.
- FETCH: fetch_en=1 for 1 cycle, then go to DECODE. Fetch outputs register on this edge.
- DECODE: decode_en=1. Sample the fetch results and latch icode. Checks are priority-ordered:
  - imem_error -> stat=3, go to HALTED.
  - else func_error -> stat=4, go to HALTED.
  - else icode==0 -> stat=2, go to HALTED.
  - else go to EXECUTE.
  - In all halt cases the PC is not updated and instr_count does not increment.
- EXECUTE: 1 cycle, then go to MEMORY.
- MEMORY, when the latched icode is not memory-class (anything other than 4, 5, 8, 9, A, B): memory_en pulses for 1 cycle, then go to WRITEBACK.
- MEMORY, when the latched icode is memory-class: memory_en is held high until exit. Exit conditions, in priority order:
  - dmem_error=1 -> stat=3, go to HALTED. dmem_error wins if it arrives in the same cycle as mem_ready.
  - mem_ready=1 -> go to WRITEBACK.
  - timeout counter == MEM_TIMEOUT -> stat=3, go to HALTED.
  - mem_ready in the first MEMORY cycle is accepted, giving a minimum of 1 cycle in MEMORY.
  - The timeout counter clears on MEMORY entry.
- WRITEBACK: 1 cycle, then go to PCUPDATE.
- PCUPDATE: pc_update_en=1. instr_count increments. Then go to FETCH.
- Steady-state latency: 6 cycles per instruction when memory responds in 1 cycle.
- HALTED: halted=1 and stat holds its fault/halt code. start is ignored. Exit only via rst.
- cycle_count increments on every cycle not spent in IDLE or HALTED.
- Both counters saturate at all-ones and do not wrap.
- mem_ready or dmem_error arriving outside MEMORY is ignored.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined, add an input port step (1 bit). After PCUPDATE the controller enters a PAUSE state:
  - all enables 0, halted=0, cycle_count frozen;
  - a step=1 sample moves to FETCH on the next cycle;
  - the first instruction after IDLE also requires step rather than start alone.
- When undefined, there is no step port and no PAUSE state, and PCUPDATE goes directly to FETCH.

Test Plan:
- Reset, then start=1 with icode=1 (nop) repeated -> enables rotate one-hot in fetch, decode, execute, memory, writeback, pc_update order at 6 cycles per instruction; instr_count=3 after 18 active cycles; stat=1.
- icode=5 (mrmovq) with mem_ready asserted 4 cycles after MEMORY entry -> memory_en high exactly 4 cycles, then writeback_en; instr_count +1.
- icode=4, mem_ready never asserted, MEM_TIMEOUT=15 -> after 15 cycles in MEMORY: stat=3, halted=1, pc_update_en never asserted.
- Fault priorities: imem_error=1 at DECODE -> stat=3; func_error=1 alone -> stat=4; icode=0 -> stat=2. In each case halted=1 and later start pulses are ignored.
- dmem_error=1 and mem_ready=1 in the same MEMORY cycle -> stat=3, no writeback_en.
- rst=1 asserted during MEMORY wait -> next cycle all outputs at reset values, state IDLE. With SEQ_SINGLE_STEP_EN, each step pulse retires exactly one instruction.
